// File: rtl/ysyx_22040895_imem_resp_pkg.sv
// Shared definitions for the instruction-memory responder: bus widths,
// default base address, FSM state encoding and the address check helper.
// Optional feature macro: YSYX_22040895_RAND_DELAY_EN (random extra latency).
package ysyx_22040895_imem_resp_pkg;

  // Instruction bus and instruction address bus widths
  localparam int unsigned INST_W      = 32;
  localparam int unsigned INST_ADDR_W = 64;

  // Byte address of word 0 unless overridden
  localparam logic [INST_ADDR_W-1:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

  // Down-counter width: LATENCY up to 15 plus up to 3 random extra cycles
  localparam int unsigned CNT_W = 5;

  // Seed of the latency-jitter LFSR
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Misaligned or outside [base, base + 4*2^depth_log2).
  // The upper bound is formed in 65 bits so a window ending at the top of
  // the 64-bit space never wraps around and aliases low addresses.
  function automatic logic addr_err(input logic [INST_ADDR_W-1:0] addr,
                                    input logic [INST_ADDR_W-1:0] base,
                                    input int unsigned            depth_log2);
    logic [INST_ADDR_W:0] limit;
    limit = {1'b0, base} + ((INST_ADDR_W+1)'(4) << depth_log2);
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/ysyx_22040895_lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, used to add 0..3
// cycles of jitter to each fetch. delay_o shows the low bits of the state
// the register will take on the next advance, so the request that causes
// the advance is the one that uses the advanced value.
module ysyx_22040895_lfsr8
  import ysyx_22040895_imem_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,      // asynchronous, active-low
  input  logic       adv_i,    // step once (one accepted request)
  output logic [1:0] delay_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign delay_o = lfsr_d[1:0];

  // LFSR state: reseeded on reset, stepped once per accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (adv_i) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/ysyx_22040895_imem_resp.sv
// Instruction-memory responder: single outstanding fetch, fixed (or, with
// YSYX_22040895_RAND_DELAY_EN defined, jittered) latency from request accept
// to rsp_valid_o, word-addressed RAM preloaded through the ld_* port.
module ysyx_22040895_imem_resp
  import ysyx_22040895_imem_resp_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int unsigned            DEPTH_LOG2 = 12,
  parameter int unsigned            LATENCY    = 2   // legal 1..15
) (
  input  logic                   clk,
  input  logic                   rst,          // asynchronous, active-low
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [INST_ADDR_W-1:0] req_addr_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [INST_W-1:0]      rsp_inst_o,
  output logic                   rsp_err_o,
  input  logic                   ld_we_i,
  input  logic [DEPTH_LOG2-1:0]  ld_addr_i,
  input  logic [INST_W-1:0]      ld_data_i
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  err_q, err_d;
  logic [INST_W-1:0]     rd_data_q;
  logic [INST_W-1:0]     mem [DEPTH];

  logic                  accept;
  logic                  capture;
  logic [CNT_W-1:0]      load_cnt;

  assign accept  = req_valid_i && (state_q == ST_IDLE);
  assign capture = (state_q == ST_WAIT) && (cnt_q == '0);

`ifdef YSYX_22040895_RAND_DELAY_EN
  logic [1:0] rand_delay;

  ysyx_22040895_lfsr8 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (accept),
    .delay_o (rand_delay)
  );

  // Count loaded at accept: LATENCY-1 plus this request's jitter
  assign load_cnt = CNT_W'(LATENCY - 1) + CNT_W'(rand_delay);
`else
  assign load_cnt = CNT_W'(LATENCY - 1);
`endif

  // Control state: FSM, down-counter, latched word index and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = load_cnt;
          // Offset wraps harmlessly for bad addresses; err_d masks the data
          idx_d   = DEPTH_LOG2'((req_addr_i - BASE_ADDR) >> 2);
          err_d   = addr_err(req_addr_i, BASE_ADDR, DEPTH_LOG2);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM: preload writes at any time; registered read on the capture edge.
  // A write to the word being captured on the same edge returns old data.
  always_ff @(posedge clk) begin
    if (ld_we_i) begin
      mem[ld_addr_i] <= ld_data_i;
    end
    if (capture) begin
      rd_data_q <= mem[idx_q];
    end
  end

  // Outputs are decoded from the state so reset clears them at once
  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_inst_o  = (rsp_valid_o && !err_q) ? rd_data_q : '0;

endmodule
